// File: rtl/jt49_bus_sched.sv
// Round-robin scheduler sharing one jt49_bus PSG between a CPU port (A) and a
// player port (B); sequences the BDIR/BC1 latch/gap/transfer/gap bus protocol.
module jt49_bus_sched #(
  parameter int unsigned PHASE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic       a_rd,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic       b_rd,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_data,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       rdata_id,
  output logic       psg_bdir,
  output logic       psg_bc1,
  output logic [7:0] psg_din,
  input  logic [7:0] psg_dout,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    GAP1  = 3'd2,
    XFER  = 3'd3,
    GAP2  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYC - 1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        last_grant_r, last_grant_s;
  logic        op_rd_r, op_rd_s;
  logic [3:0]  op_addr_r, op_addr_s;
  logic [7:0]  op_data_r, op_data_s;
  logic        op_id_r, op_id_s;
  logic        grant_id_s, hs_s;
  logic        bdir_s, bc1_s;
  logic [7:0]  din_s;
  logic        bdir_r, bc1_r, busy_r;
  logic [7:0]  din_r;
  logic [7:0]  rdata_r;
  logic        rdata_valid_r, rdata_id_r;

  // Arbitration: a lone requester wins, otherwise the port not granted last time
  always_comb begin
    grant_id_s = 1'b0;
    if (a_valid && b_valid) begin
      grant_id_s = ~last_grant_r;
    end else if (b_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
    hs_s = (state_r == IDLE) && (a_valid || b_valid);
  end

  assign a_ready = hs_s && !grant_id_s;
  assign b_ready = hs_s && grant_id_s;

  // Next-state, op capture and the bus encoding of the upcoming state
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    last_grant_s = last_grant_r;
    op_rd_s      = op_rd_r;
    op_addr_s    = op_addr_r;
    op_data_s    = op_data_r;
    op_id_s      = op_id_r;
    bdir_s       = 1'b0;
    bc1_s        = 1'b0;
    din_s        = 8'h00;
    case (state_r)
      IDLE: begin
        if (hs_s) begin
          state_s      = LATCH;
          cnt_s        = 4'd0;
          last_grant_s = grant_id_s;
          op_id_s      = grant_id_s;
          op_rd_s      = grant_id_s ? b_rd   : a_rd;
          op_addr_s    = grant_id_s ? b_addr : a_addr;
          op_data_s    = grant_id_s ? b_data : a_data;
        end else begin
          state_s = IDLE;
        end
      end
      LATCH: begin
        if (cnt_r == LAST_CNT) begin
          state_s = GAP1;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      GAP1: begin
        state_s = XFER;
        cnt_s   = 4'd0;
      end
      XFER: begin
        if (cnt_r == LAST_CNT) begin
          state_s = GAP2;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      GAP2: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase

    // Encoding follows state_s so the bus pins register on the same edge as the state
    case (state_s)
      LATCH: begin
        bdir_s = 1'b1;
        bc1_s  = 1'b1;
        din_s  = {4'b0000, op_addr_s};
      end
      XFER: begin
        if (op_rd_s) begin
          bc1_s = 1'b1;
        end else begin
          bdir_s = 1'b1;
          din_s  = op_data_s;
        end
      end
      default: begin
        bdir_s = 1'b0;
        bc1_s  = 1'b0;
        din_s  = 8'h00;
      end
    endcase
  end

  // State, op registers and registered bus/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      last_grant_r  <= 1'b1;
      op_rd_r       <= 1'b0;
      op_addr_r     <= 4'h0;
      op_data_r     <= 8'h00;
      op_id_r       <= 1'b0;
      bdir_r        <= 1'b0;
      bc1_r         <= 1'b0;
      din_r         <= 8'h00;
      busy_r        <= 1'b0;
      rdata_r       <= 8'h00;
      rdata_valid_r <= 1'b0;
      rdata_id_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      last_grant_r <= last_grant_s;
      op_rd_r      <= op_rd_s;
      op_addr_r    <= op_addr_s;
      op_data_r    <= op_data_s;
      op_id_r      <= op_id_s;
      bdir_r       <= bdir_s;
      bc1_r        <= bc1_s;
      din_r        <= din_s;
      busy_r       <= (state_s != IDLE);
      // PSG read data is stable in GAP2; result is announced in the first IDLE cycle
      if ((state_r == GAP2) && op_rd_r) begin
        rdata_r       <= psg_dout;
        rdata_valid_r <= 1'b1;
        rdata_id_r    <= op_id_r;
      end else begin
        rdata_valid_r <= 1'b0;
      end
    end
  end

  assign psg_bdir    = bdir_r;
  assign psg_bc1     = bc1_r;
  assign psg_din     = din_r;
  assign busy        = busy_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign rdata_id    = rdata_id_r;

endmodule

// File: tb/tb_jt49_bus_sched.sv
// Bench for jt49_bus_sched: a transaction-level model predicts grants, bus
// phases and read results; a behavioural PSG register file sits on the bus.
module tb_jt49_bus_sched;

  localparam int MAXC = 2048;
  localparam int P1   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_valid, a_ready, a_rd, b_valid, b_ready, b_rd;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_data, b_data, rdata, psg_din, psg_dout;
  logic       rdata_valid, rdata_id, psg_bdir, psg_bc1, busy;

  jt49_bus_sched #(.PHASE_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_addr(b_addr), .b_data(b_data),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_id(rdata_id),
    .psg_bdir(psg_bdir), .psg_bc1(psg_bc1), .psg_din(psg_din), .psg_dout(psg_dout),
    .busy(busy)
  );

  logic       p3_a_valid, p3_a_ready, p3_a_rd, p3_b_ready;
  logic [3:0] p3_a_addr;
  logic [7:0] p3_a_data, p3_rdata, p3_din, p3_dout;
  logic       p3_rdata_valid, p3_rdata_id, p3_bdir, p3_bc1, p3_busy;

  jt49_bus_sched #(.PHASE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(p3_a_valid), .a_ready(p3_a_ready), .a_rd(p3_a_rd), .a_addr(p3_a_addr), .a_data(p3_a_data),
    .b_valid(1'b0), .b_ready(p3_b_ready), .b_rd(1'b0), .b_addr(4'h0), .b_data(8'h00),
    .rdata(p3_rdata), .rdata_valid(p3_rdata_valid), .rdata_id(p3_rdata_id),
    .psg_bdir(p3_bdir), .psg_bc1(p3_bc1), .psg_din(p3_din), .psg_dout(p3_dout),
    .busy(p3_busy)
  );

  // Behavioural PSG register files driven by each scheduler's bus
  logic [7:0] psg_regs [16];
  logic [7:0] p3_regs [16];
  logic [3:0] psg_sel, p3_sel;
  always @(posedge clk) begin
    if ({psg_bdir, psg_bc1} == 2'b11) psg_sel <= psg_din[3:0];
    else if ({psg_bdir, psg_bc1} == 2'b10) psg_regs[psg_sel] <= psg_din;
    if ({p3_bdir, p3_bc1} == 2'b11) p3_sel <= p3_din[3:0];
    else if ({p3_bdir, p3_bc1} == 2'b10) p3_regs[p3_sel] <= p3_din;
  end
  assign psg_dout = psg_regs[psg_sel];
  assign p3_dout  = p3_regs[p3_sel];

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } req_t;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc, free_at, hs_cnt;
  logic       lg, a_on, b_on, rnd;
  logic [7:0] mregs [16];
  logic [7:0] cur_rdata;
  logic [9:0] exp_bus  [MAXC];
  logic       exp_busy [MAXC];
  logic [9:0] exp_rv   [MAXC];
  req_t       aq[$], bq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_from(input int t0);
    for (int t = t0; t < MAXC; t++) begin
      exp_bus[t]  = 10'h000;
      exp_busy[t] = 1'b0;
      exp_rv[t]   = 10'h000;
    end
  endtask

  // Model of one accepted request: L = 2P+2 bus cycles starting next cycle
  task automatic schedule(input req_t r, input logic id);
    int L, t;
    logic [9:0] v;
    L = 2 * P1 + 2;
    for (int k = 0; k < L; k++) begin
      t = cyc + 1 + k;
      if (k < P1) v = {2'b11, 4'h0, r.addr};
      else if (k == P1 || k == L - 1) v = 10'h000;
      else if (r.rd) v = {2'b01, 8'h00};
      else v = {2'b10, r.data};
      if (t < MAXC) begin
        exp_bus[t]  = v;
        exp_busy[t] = 1'b1;
      end
    end
    if (r.rd) begin
      if (cyc + L + 1 < MAXC) exp_rv[cyc + L + 1] = {1'b1, id, mregs[r.addr]};
    end else begin
      mregs[r.addr] = r.data;
    end
    free_at = cyc + L + 1;
    lg      = id;
    hs_cnt++;
  endtask

  task automatic check_outputs();
    chk("bus", 32'({psg_bdir, psg_bc1, psg_din}), 32'(exp_bus[cyc]));
    chk("busy", 32'(busy), 32'(exp_busy[cyc]));
    chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv[cyc][9]));
    if (exp_rv[cyc][9]) begin
      cur_rdata = exp_rv[cyc][7:0];
      chk("rdata_id", 32'(rdata_id), 32'(exp_rv[cyc][8]));
    end
    chk("rdata", 32'(rdata), 32'(cur_rdata));
  endtask

  // One cycle: check registered outputs, present requests, check the grant
  task automatic cycle();
    logic ea, eb;
    req_t r;
    check_outputs();
    if (!a_on && aq.size() > 0) a_on = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
    if (!b_on && bq.size() > 0) b_on = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
    a_valid = a_on;
    b_valid = b_on;
    if (a_on) {a_rd, a_addr, a_data} = aq[0];
    else {a_rd, a_addr, a_data} = 13'($urandom);
    if (b_on) {b_rd, b_addr, b_data} = bq[0];
    else {b_rd, b_addr, b_data} = 13'($urandom);
    #1;
    ea = 1'b0;
    eb = 1'b0;
    if (cyc >= free_at && (a_on || b_on)) begin
      if (a_on && b_on) eb = ~lg;
      else eb = b_on;
      ea = ~eb;
    end
    chk("a_ready", 32'(a_ready), 32'(ea));
    chk("b_ready", 32'(b_ready), 32'(eb));
    chk("ready_excl", 32'(a_ready & b_ready), 32'h0);
    if (ea) begin
      r = aq.pop_front();
      a_on = 1'b0;
      schedule(r, 1'b0);
    end else if (eb) begin
      r = bq.pop_front();
      b_on = 1'b0;
      schedule(r, 1'b1);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_idle(input int cap);
    int start;
    start = cyc;
    while ((aq.size() > 0 || bq.size() > 0 || cyc <= free_at) && (cyc - start) < cap) cycle();
    chk("timeout", 32'((cyc - start) < cap), 32'h1);
  endtask

  initial begin
    req_t r;
    int   hs0;
    rst_n = 1'b1;
    {a_valid, a_rd, a_addr, a_data, b_valid, b_rd, b_addr, b_data} = '0;
    {p3_a_valid, p3_a_rd, p3_a_addr, p3_a_data} = '0;
    for (int i = 0; i < 16; i++) begin
      psg_regs[i] = 8'h00;
      p3_regs[i]  = 8'h00;
      mregs[i]    = 8'h00;
    end
    psg_sel = 4'h0;
    p3_sel  = 4'h0;
    lg = 1'b1; a_on = 1'b0; b_on = 1'b0; rnd = 1'b0;
    free_at = 0; hs_cnt = 0; cur_rdata = 8'h00; cyc = 0;
    clear_from(0);

    #1 rst_n = 1'b0;
    #1;
    chk("rst_outs", 32'({psg_bdir, psg_bc1, psg_din, rdata, rdata_valid, rdata_id, busy, a_ready, b_ready}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then read-back from the other port
    aq.push_back({1'b0, 4'h7, 8'h38});
    run_until_idle(50);
    chk("psg_reg7", 32'(psg_regs[7]), 32'h38);
    bq.push_back({1'b1, 4'h7, 8'h00});
    run_until_idle(50);

    // Contention: three requests on each port, both held valid
    for (int i = 0; i < 3; i++) begin
      aq.push_back({1'b0, 4'(i), 8'(8'h10 + i)});
      bq.push_back({1'b0, 4'(i + 8), 8'(8'h20 + i)});
    end
    run_until_idle(100);

    // Back-to-back on port A
    aq.push_back({1'b0, 4'h3, 8'hA5});
    aq.push_back({1'b1, 4'h3, 8'h00});
    run_until_idle(50);

    // Randomized mixed traffic
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r = {1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 8'($urandom)};
      if ($urandom_range(1, 0) == 1) aq.push_back(r);
      else bq.push_back(r);
    end
    run_until_idle(1000);
    rnd = 1'b0;

    // Reset during the transfer phase of a read
    aq.push_back({1'b1, 4'h7, 8'h00});
    hs0 = hs_cnt;
    for (int i = 0; i < 20 && hs_cnt == hs0; i++) cycle();
    chk("rst_hs_seen", 32'(hs_cnt - hs0), 32'h1);
    cycle();
    cycle();
    check_outputs();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bus", 32'({psg_bdir, psg_bc1}), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_rv", 32'(rdata_valid), 32'h0);
    clear_from(cyc + 1);
    lg = 1'b1; free_at = 0; cur_rdata = 8'h00;
    a_on = 1'b0; b_on = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    aq.delete();
    bq.delete();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    aq.push_back({1'b0, 4'h5, 8'h5A});
    bq.push_back({1'b1, 4'h5, 8'h00});
    run_until_idle(50);

    // Longer phases on the PHASE_CYC=3 instance
    p3_a_valid = 1'b1;
    p3_a_rd    = 1'b0;
    p3_a_addr  = 4'hD;
    p3_a_data  = 8'h0E;
    #1;
    chk("p3_ready", 32'(p3_a_ready), 32'h1);
    @(negedge clk);
    p3_a_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [9:0] v;
      if (k < 3) v = {2'b11, 8'h0D};
      else if (k == 3 || k == 7 || k == 8) v = 10'h000;
      else v = {2'b10, 8'h0E};
      chk("p3_bus", 32'({p3_bdir, p3_bc1, p3_din}), 32'(v));
      chk("p3_busy", 32'(p3_busy), 32'(k < 8));
      chk("p3_ready_idle", 32'(p3_a_ready), 32'h0);
      @(negedge clk);
    end
    chk("p3_reg13", 32'(p3_regs[13]), 32'h0E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
